ram_arbiter: RTL and testbench

Sequences and shares the single byte-wide RAM port between the instruction-fetch requester and the load/store requester. Requests are arbitrated with load/store priority and bounded fetch starvation. Each granted access is broken into 1, 2 or 4 byte-serial RAM cycles. The block returns assembled little-endian words with a one-cycle done pulse. It sits between the fetch/load-store front ends and the RAM, and owns every RAM-side signal.

---
 rtl/ram_arbiter_if.sv | 44 ++++
 rtl/ram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the byte-wide RAM port shared by
// ram_arbiter. The slave modport is the arbiter's view; master is the
// view of whatever drives the requests and models the RAM.
interface ram_arbiter_if;
  // instruction-fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_grant;
  logic        if_done;
  logic [31:0] if_data;

  // load/store requester
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_grant;
  logic        ls_done;
  logic [31:0] ls_rdata;

  // fetch kill
  logic        flush;

  // byte-wide RAM port
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
           flush, ram_din,
    output if_grant, if_done, if_data, ls_grant, ls_done, ls_rdata,
           ram_a, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
           flush, ram_din,
    input  if_grant, if_done, if_data, ls_grant, ls_done, ls_rdata,
           ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch (IF) and
// load/store (LS). LS has priority; after StarveLimit consecutive LS grants
// taken while a fetch was waiting, the fetch is forced through. Each grant
// is split into 1, 2 or 4 byte-serial RAM cycles; read bytes are assembled
// little-endian and returned with a one-cycle done pulse. Every output is a
// register.
module ram_arbiter #(
  parameter int StarveLimit = 4
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  starve;
  logic [2:0]  nbytes;
  logic        owner_ls;
  logic [31:0] wdata_q;
  logic [31:0] asm_q;

  logic        starved;
  logic        if_win;
  logic        ls_win;
  logic        if_kill;
  logic        last_byte;
  logic [31:0] asm_next;

  // Byte count of a load/store; size 10 and 11 both mean a full word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Replace byte lane idx of a word (lane k = bits [8k+7:8k]).
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Extract byte lane idx of a word.
  function automatic logic [7:0] get_byte(input logic [31:0] word,
                                          input logic [1:0]  idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  // Arbitration: LS first unless the fetch has been starved to the limit.
  // A fetch is never accepted while flush is high; LS may still go then.
  assign starved  = (starve == 3'(StarveLimit));
  assign if_win   = bus.if_req && !bus.flush && (!bus.ls_req || starved);
  assign ls_win   = bus.ls_req && !if_win;

  // Flush only ever kills a read owned by the fetch side.
  assign if_kill  = (state == RD) && !owner_ls && bus.flush;

  // cnt counts edges since the grant edge, minus one. In RD, ram_din at
  // edge cnt carries byte cnt-1 (one cycle of RAM latency behind ram_a).
  assign last_byte = (cnt + 3'd1 >= nbytes);
  assign asm_next  = put_byte(asm_q, 2'(cnt - 3'd1), bus.ram_din);

  // Control FSM, grant/done pulses, RAM port and returned data words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      starve       <= 3'd0;
      nbytes       <= 3'd0;
      owner_ls     <= 1'b0;
      bus.if_grant <= 1'b0;
      bus.if_done  <= 1'b0;
      bus.if_data  <= 32'd0;
      bus.ls_grant <= 1'b0;
      bus.ls_done  <= 1'b0;
      bus.ls_rdata <= 32'd0;
      bus.ram_a    <= 32'd0;
      bus.ram_dout <= 8'd0;
      bus.ram_wr   <= 1'b0;
    end else begin
      bus.if_grant <= 1'b0;
      bus.ls_grant <= 1'b0;
      bus.if_done  <= 1'b0;
      bus.ls_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_win) begin
            bus.if_grant <= 1'b1;
            owner_ls     <= 1'b0;
            nbytes       <= 3'd4;
            bus.ram_a    <= bus.if_addr;
            cnt          <= 3'd0;
            starve       <= 3'd0;
            state        <= RD;
          end else if (ls_win) begin
            bus.ls_grant <= 1'b1;
            owner_ls     <= 1'b1;
            nbytes       <= size_to_n(bus.ls_size);
            bus.ram_a    <= bus.ls_addr;
            cnt          <= 3'd0;
            if (bus.if_req && !starved) begin
              starve <= starve + 3'd1;
            end
            if (bus.ls_we) begin
              bus.ram_wr   <= 1'b1;
              bus.ram_dout <= bus.ls_wdata[7:0];
              state        <= WR;
            end else begin
              state <= RD;
            end
          end
        end

        RD: begin
          if (if_kill) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
            if (!last_byte) begin
              bus.ram_a <= bus.ram_a + 32'd1;
            end
            if (cnt == nbytes) begin
              state <= IDLE;
              if (owner_ls) begin
                bus.ls_done  <= 1'b1;
                bus.ls_rdata <= asm_next;
              end else begin
                bus.if_done <= 1'b1;
                bus.if_data <= asm_next;
              end
            end
          end
        end

        WR: begin
          cnt <= cnt + 3'd1;
          if (!last_byte) begin
            bus.ram_a    <= bus.ram_a + 32'd1;
            bus.ram_dout <= get_byte(wdata_q, 2'(cnt + 3'd1));
          end else begin
            bus.ram_wr  <= 1'b0;
            bus.ls_done <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Data-only registers: store data latched at grant, read bytes assembled
  // as they arrive. Cleared in IDLE so short loads come back zero-extended.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      asm_q <= 32'd0;
      if (ls_win) begin
        wdata_q <= bus.ls_wdata;
      end
    end else if (state == RD && cnt != 3'd0) begin
      asm_q <= asm_next;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: byte RAM model, per-cycle monitor with an
// expected-result queue, a vector table and hand-written corner sequences.
module tb_ram_arbiter;

  logic clk;
  logic rst;

  ram_arbiter_if bus ();

  ram_arbiter #(.StarveLimit(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ls;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
  } vec_t;

  int   checks;
  int   failures;
  vec_t exp_q[$];
  bit   grant_log[$];
  vec_t cur_if;
  vec_t cur_ls;
  vec_t act;
  bit   busy;
  int   k;
  bit   grant_seen;
  bit   grant_ls;
  bit   done_seen;

  // Byte RAM: registered read data, one cycle behind the address.
  logic [7:0] mem [0:1023];

  function automatic logic [7:0] init_byte(input logic [9:0] a);
    case (a)
      10'h100: return 8'h11;
      10'h101: return 8'h22;
      10'h102: return 8'h33;
      10'h103: return 8'h44;
      default: return a[7:0] + 8'h30;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= init_byte(10'(i));
    bus.ram_din <= 8'h00;
    forever begin
      @(posedge clk);
      if (bus.ram_wr) mem[bus.ram_a[9:0]] <= bus.ram_dout;
      bus.ram_din <= mem[bus.ram_a[9:0]];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic ls, input logic we,
                              input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata,
                              input logic [31:0] exp_data);
    vec_t v;
    v.ls = ls; v.we = we; v.size = size;
    v.addr = addr; v.wdata = wdata; v.exp_data = exp_data;
    return v;
  endfunction

  function automatic int nbytes(input vec_t v);
    if (!v.ls) return 4;
    case (v.size)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ram_a"},    bus.ram_a, 32'd0);
    check({tag, "_ram_dout"}, 32'(bus.ram_dout), 32'd0);
    check({tag, "_pulses"},   32'({bus.ram_wr, bus.if_grant, bus.ls_grant,
                                   bus.if_done, bus.ls_done}), 32'd0);
    check({tag, "_if_data"},  bus.if_data, 32'd0);
    check({tag, "_ls_rdata"}, bus.ls_rdata, 32'd0);
  endtask

  // Per-cycle observer: tracks the active transfer, checks the RAM port
  // each cycle and compares every done against the expected queue.
  task automatic monitor();
    vec_t e;
    int   n;
    grant_seen = 0;
    done_seen  = 0;
    if (bus.if_grant || bus.ls_grant) begin
      check("grant_exclusive", 32'(bus.if_grant & bus.ls_grant), 32'd0);
      check("grant_while_busy", 32'(busy), 32'd0);
      grant_seen = 1;
      grant_ls   = bus.ls_grant;
      grant_log.push_back(bus.ls_grant);
      act  = bus.ls_grant ? cur_ls : cur_if;
      busy = 1;
      k    = 0;
      exp_q.push_back(act);
    end else if (busy) begin
      k++;
    end
    if (busy) begin
      n = nbytes(act);
      check("ram_a", bus.ram_a, act.addr + 32'((k < n) ? k : n - 1));
      check("ram_wr", 32'(bus.ram_wr), 32'(act.we && (k < n)));
      if (act.we && k < n)
        check("ram_dout", 32'(bus.ram_dout), (act.wdata >> (8 * k)) & 32'hFF);
    end else begin
      check("ram_wr_idle", 32'(bus.ram_wr), 32'd0);
    end
    if (bus.if_done || bus.ls_done) begin
      done_seen = 1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: if_done=%0b ls_done=%0b, expected none",
                 bus.if_done, bus.ls_done);
      end else begin
        e = exp_q.pop_front();
        n = nbytes(e);
        check("done_owner", 32'(bus.ls_done), 32'(e.ls));
        check("done_latency", 32'(k), 32'(e.we ? n : n + 1));
        if (!e.we)
          check(e.ls ? "ls_rdata" : "if_data",
                e.ls ? bus.ls_rdata : bus.if_data, e.exp_data);
      end
      busy = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_grant(input string name, input int maxc, output int taken);
    taken = 0;
    grant_seen = 0;
    while (!grant_seen && taken < maxc) begin
      step();
      taken++;
    end
    checks++;
    if (!grant_seen) begin
      failures++;
      $display("FAIL %s: no grant within %0d cycles", name, maxc);
    end
  endtask

  task automatic wait_done(input string name, input int maxc);
    int c;
    c = 0;
    done_seen = 0;
    while (!done_seen && c < maxc) begin
      step();
      c++;
    end
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL %s: no done within %0d cycles", name, maxc);
    end
  endtask

  task automatic drive(input vec_t v);
    if (v.ls) begin
      cur_ls       = v;
      bus.ls_we    = v.we;
      bus.ls_size  = v.size;
      bus.ls_addr  = v.addr;
      bus.ls_wdata = v.wdata;
      bus.ls_req   = 1'b1;
    end else begin
      cur_if      = v;
      bus.if_addr = v.addr;
      bus.if_req  = 1'b1;
    end
  endtask

  vec_t vecs[9];
  bit   exp_order[6];
  int   t;

  initial begin
    checks = 0; failures = 0; busy = 0; k = 0;
    grant_seen = 0; grant_ls = 0; done_seen = 0;
    cur_if = mk(0, 0, 2'd2, 32'h0, 32'h0, 32'h0);
    cur_ls = cur_if;
    act    = cur_if;

    // {ls, we, size, addr, wdata, expected data}
    vecs[0] = mk(0, 0, 2'd2, 32'h0000_0100, 32'h0,         32'h4433_2211);
    vecs[1] = mk(1, 1, 2'd0, 32'h0000_0020, 32'hAABB_CCDD, 32'h0);
    vecs[2] = mk(1, 1, 2'd1, 32'h0000_0020, 32'hAABB_CCDD, 32'h0);
    vecs[3] = mk(1, 0, 2'd2, 32'h0000_0020, 32'h0,         32'h5352_CCDD);
    vecs[4] = mk(1, 0, 2'd0, 32'h0000_0101, 32'h0,         32'h0000_0022);
    vecs[5] = mk(1, 0, 2'd1, 32'hFFFF_FFFF, 32'h0,         32'h0000_302F);
    vecs[6] = mk(1, 1, 2'd3, 32'h0000_0040, 32'h0102_0304, 32'h0);
    vecs[7] = mk(1, 0, 2'd3, 32'h0000_0040, 32'h0,         32'h0102_0304);
    vecs[8] = mk(0, 0, 2'd2, 32'h0000_0041, 32'h0,         32'h7401_0203);
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b0;
    bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_we = 0;
    bus.ls_size = 0; bus.ls_addr = 0; bus.ls_wdata = 0; bus.flush = 0;
    step(); step(); step();
    check_zero("reset");
    rst = 1'b1;
    step();

    // Single-requester vectors
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i]);
      wait_grant("vec_grant", 4, t);
      check("vec_grant_latency", 32'(t), 32'd1);
      check("vec_grant_owner", 32'(grant_ls), 32'(vecs[i].ls));
      bus.if_req = 0;
      bus.ls_req = 0;
      wait_done("vec_done", 8);
    end

    // Both requesters held: LS, LS, IF, LS, LS, IF with limit 2
    grant_log.delete();
    drive(mk(0, 0, 2'd2, 32'h0000_0100, 32'h0, 32'h4433_2211));
    drive(mk(1, 0, 2'd0, 32'h0000_0101, 32'h0, 32'h0000_0022));
    t = 0;
    while (grant_log.size() < 6 && t < 200) begin
      step();
      t++;
    end
    bus.if_req = 0;
    bus.ls_req = 0;
    check("starve_grant_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < grant_log.size())
        check("starve_order", 32'(grant_log[i]), 32'(exp_order[i]));
    wait_done("starve_last_done", 8);

    // Flush mid-fetch (cycle 3) and on the done edge (cycle 4)
    for (int f = 3; f <= 4; f++) begin
      drive(mk(0, 0, 2'd2, 32'h0000_0040, 32'h0, 32'h0102_0304));
      wait_grant("fl_if_grant", 4, t);
      check("fl_grant_owner", 32'(grant_ls), 32'd0);
      bus.if_req = 0;
      drive(mk(1, 0, 2'd0, 32'h0000_0020, 32'h0, 32'h0000_00DD));
      for (int c = 1; c <= f; c++) step();
      bus.flush = 1;
      busy = 0;
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      step();
      bus.flush = 0;
      step();
      check("fl_ls_next_edge", 32'(grant_seen && grant_ls), 32'd1);
      bus.ls_req = 0;
      wait_done("fl_ls_done", 4);
      check("fl_if_data_hold", bus.if_data, 32'h4433_2211);
    end

    // Build starve to the limit, then reset during cycle 1 of a word store
    drive(mk(0, 0, 2'd2, 32'h0000_0100, 32'h0, 32'h4433_2211));
    drive(mk(1, 0, 2'd0, 32'h0000_0101, 32'h0, 32'h0000_0022));
    wait_grant("rst_pre_grant1", 4, t);
    check("rst_pre_owner1", 32'(grant_ls), 32'd1);
    drive(mk(1, 1, 2'd2, 32'h0000_0060, 32'hCAFE_F00D, 32'h0));
    wait_done("rst_pre_done1", 4);
    wait_grant("rst_pre_grant2", 3, t);
    check("rst_pre_owner2", 32'(grant_ls), 32'd1);
    step();
    check("rst_store_active", 32'(bus.ram_wr), 32'd1);
    rst = 1'b0;
    #1;
    check_zero("rst_async");
    busy = 0;
    exp_q.delete();
    drive(mk(1, 0, 2'd0, 32'h0000_0101, 32'h0, 32'h0000_0022));
    step();
    step();
    check_zero("rst_held");
    rst = 1'b1;
    wait_grant("rst_post_grant", 3, t);
    check("rst_post_latency", 32'(t), 32'd1);
    check("rst_post_owner_ls", 32'(grant_ls), 32'd1);
    bus.if_req = 0;
    bus.ls_req = 0;
    wait_done("rst_post_done", 4);
    step();
    step();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
